// File: rtl/ikbd_txd_deserializer.sv
// IKBD-to-host serial receiver: recovers 8N1 frames from the HD63701 SCI TXD pin
// and queues them in a first-word-fall-through FIFO with sticky error flags.
module ikbd_txd_deserializer #(
    parameter int CLKS_PER_BIT = 256,
    parameter int DEPTH        = 4
) (
    input  logic                     mcu_clx2,
    input  logic                     mcu_rst,
    input  logic                     txd_in,
    input  logic                     rx_pop,
    input  logic                     err_clr,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    output logic [$clog2(DEPTH):0]   rx_count,
    output logic                     frame_err,
    output logic                     overrun,
    output logic                     busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = AW + 1;
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]    FULL_COUNT = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Receiver state
    logic             sync1_q;
    logic             s_q;
    logic             s_prev_q;
    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q,   shift_d;
    logic             push;
    logic             frame_evt;

    // FIFO state
    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q,  wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q,  rd_ptr_d;
    logic [CW-1:0]    count_q,   count_d;
    logic [7:0]       data_q,    data_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;
    logic             do_push;
    logic             do_pop;
    logic             ovr_evt;

    // Bit-timing FSM: the counter restarts at every sample point so each
    // sample lands one full bit period after the previous one.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path leaves
        // it unassigned; a missing default would infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q + 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frame_evt = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (s_prev_q && !s_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    cnt_d = '0;
                    if (s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_idx_d = '0;
                    end
                end
            end
            S_DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {s_q, shift_q[7:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (s_q) begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        frame_evt = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                cnt_d = '0;
                if (s_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a
    // byte that completes while it is being read.
    always_comb begin
        do_pop   = rx_pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_COUNT) || do_pop);
        ovr_evt  = push && !do_push;

        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (count_d == '0) begin
            data_d = data_q;
        end else if (do_push && (wr_ptr_q == rd_ptr_d)) begin
            data_d = shift_q;
        end else begin
            data_d = mem_q[rd_ptr_d];
        end

        frame_err_d = frame_evt | (frame_err_q & ~err_clr);
        overrun_d   = ovr_evt   | (overrun_q   & ~err_clr);
    end

    always_ff @(posedge mcu_clx2 or posedge mcu_rst) begin
        if (mcu_rst) begin
            sync1_q     <= 1'b1;
            s_q         <= 1'b1;
            s_prev_q    <= 1'b1;
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_q      <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // NOTE: state flops use non-blocking assignments so every flop
            // samples pre-edge values regardless of statement order.
            sync1_q     <= txd_in;
            s_q         <= sync1_q;
            s_prev_q    <= s_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_q      <= data_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    // NOTE: FIFO storage has no reset; it is only ever read through data_q,
    // which is reset and only loads entries that have been written.
    always_ff @(posedge mcu_clx2) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = (count_q != '0);
    assign rx_count  = count_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != S_IDLE);

endmodule
